frame_prefetch: RTL and testbench

FRAME_PREFETCH -- requirements
Module: frame_prefetch

---
 rtl/sdram_pkg.sv | 13 +
 rtl/sync_fifo.sv | 60 ++++++
 rtl/frame_prefetch.sv | 112 +++++++++++
 tb/tb_frame_prefetch.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_pkg.sv
// Types shared by the SDRAM-facing blocks: word address and prefetch FSM states.
package sdram_pkg;

  typedef logic [24:0] sdram_addr_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_FREE,
    ST_DONE
  } pf_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous first-word-fall-through FIFO with flush; head word reads as zero when empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [AW:0]      cnt_q;
  logic             do_push, do_pop;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CNT_FULL);
  assign count   = cnt_q;
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && !flush && (!full || do_pop);
  assign rdata   = empty ? '0 : mem_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + PTR_ONE;
      if (do_pop)  rptr_q <= rptr_q + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_ONE;
        2'b01:   cnt_q <= cnt_q - CNT_ONE;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage carries no reset; empty masks stale contents on rdata.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata;
  end

endmodule

// File: rtl/frame_prefetch.sv
// Streams a frame of SDRAM words into a small FIFO, one read outstanding at a time,
// throttled so the in-flight word always has a free slot to land in.
module frame_prefetch
  import sdram_pkg::*;
#(
  parameter int          DEPTH       = 16,
  parameter sdram_addr_t BASE_ADDR   = 25'h0,
  parameter int unsigned FRAME_WORDS = 76800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  output logic        mem_read_req,
  output sdram_addr_t mem_address,
  input  logic        mem_ready,
  input  logic [31:0] mem_data,
  input  logic        pop,
  output logic [31:0] pix_data,
  output logic        pix_valid,
  output logic        underflow
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [23:0]   LAST_IDX = 24'(FRAME_WORDS - 1);
  localparam logic [23:0]   IDX_ONE  = 24'd1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] TWO_C    = CW'(2);

  pf_state_e     state_q, state_d;
  logic [23:0]   idx_q, idx_d;
  logic          discard_q, discard_d;
  logic          underflow_q, underflow_d;
  logic          fifo_push, fifo_full, fifo_empty;
  logic [CW-1:0] fifo_count, free_slots;

  assign free_slots  = DEPTH_C - fifo_count;
  assign mem_address = BASE_ADDR + {1'b0, idx_q};
  assign pix_valid   = !fifo_empty;
  assign underflow   = underflow_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      discard_q   <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      discard_q   <= discard_d;
      underflow_q <= underflow_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    discard_d    = discard_q;
    underflow_d  = underflow_q;
    fifo_push    = 1'b0;
    mem_read_req = 1'b0;
    if (pop && fifo_empty) underflow_d = 1'b1;

    case (state_q)
      ST_REQ: begin
        // While an abandoned read is still in flight, hold off the new request.
        mem_read_req = !discard_q && !mem_ready;
        if (mem_ready) begin
          if (discard_q) begin
            discard_d = 1'b0;
          end else begin
            fifo_push = 1'b1;
            idx_d     = idx_q + IDX_ONE;
            if (idx_q == LAST_IDX)       state_d = ST_DONE;
            else if (free_slots <= TWO_C) state_d = ST_WAIT_FREE;
          end
        end
      end
      ST_WAIT_FREE: if (free_slots >= TWO_C) state_d = ST_REQ;
      ST_IDLE, ST_DONE: state_d = state_q;
      default: state_d = ST_IDLE;
    endcase

    if (frame_start) begin
      state_d     = ST_REQ;
      idx_d       = '0;
      underflow_d = 1'b0;
      fifo_push   = 1'b0;
      discard_d   = (state_q == ST_REQ) && !mem_ready;
    end
  end

  sync_fifo #(
    .WIDTH (32),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (frame_start),
    .push  (fifo_push),
    .wdata (mem_data),
    .pop   (pop),
    .rdata (pix_data),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  push_full_a: assert property (@(posedge clk) disable iff (rst)
    !(fifo_push && fifo_full && !pop));

endmodule

// File: tb/tb_frame_prefetch.sv
// Randomized bench: memory responders plus a frame-order scoreboard for two configurations.
module tb_frame_prefetch;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        frame_start = 1'b0, mem_ready = 1'b0, pop = 1'b0;
  logic [31:0] mem_data = '0;
  logic        mem_read_req, pix_valid, underflow;
  logic [24:0] mem_address;
  logic [31:0] pix_data;

  logic        frame_start2 = 1'b0, mem_ready2 = 1'b0, pop2 = 1'b0;
  logic [31:0] mem_data2 = '0;
  logic        mem_read_req2, pix_valid2, underflow2;
  logic [24:0] mem_address2;
  logic [31:0] pix_data2;

  int errors = 0;
  int checks = 0;
  logic [24:0] req_log[$];
  logic [24:0] req_log2[$];
  bit          busy = 0, busy2 = 0;
  logic [24:0] cur = '0, cur2 = '0;
  int          wcnt = 0, wcnt2 = 0;

  always #5 clk = ~clk;

  frame_prefetch #(.DEPTH(16), .BASE_ADDR(25'h0), .FRAME_WORDS(40)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start),
    .mem_read_req(mem_read_req), .mem_address(mem_address),
    .mem_ready(mem_ready), .mem_data(mem_data), .pop(pop),
    .pix_data(pix_data), .pix_valid(pix_valid), .underflow(underflow));

  frame_prefetch #(.DEPTH(4), .BASE_ADDR(25'h1FFFFFE), .FRAME_WORDS(4)) dut2 (
    .clk(clk), .rst(rst), .frame_start(frame_start2),
    .mem_read_req(mem_read_req2), .mem_address(mem_address2),
    .mem_ready(mem_ready2), .mem_data(mem_data2), .pop(pop2),
    .pix_data(pix_data2), .pix_valid(pix_valid2), .underflow(underflow2));

  // Memory for dut: word value equals its address, completion 3 cycles after request.
  always @(negedge clk) begin
    if (rst) begin
      busy = 0; mem_ready = 1'b0;
    end else if (mem_ready) begin
      mem_ready = 1'b0; busy = 0;
    end else if (busy) begin
      if (mem_read_req) begin
        checks++;
        if (mem_address !== cur) begin
          errors++;
          $display("FAIL req_while_busy: addr %0h while %0h outstanding", mem_address, cur);
        end
      end
      if (wcnt == 0) begin mem_ready = 1'b1; mem_data = {7'b0, cur}; end
      else wcnt--;
    end else if (mem_read_req) begin
      busy = 1; cur = mem_address; wcnt = 1; req_log.push_back(mem_address);
    end
  end

  // Memory for dut2: random completion latency.
  always @(negedge clk) begin
    if (rst) begin
      busy2 = 0; mem_ready2 = 1'b0;
    end else if (mem_ready2) begin
      mem_ready2 = 1'b0; busy2 = 0;
    end else if (busy2) begin
      if (mem_read_req2) begin
        checks++;
        if (mem_address2 !== cur2) begin
          errors++;
          $display("FAIL req_while_busy2: addr %0h while %0h outstanding", mem_address2, cur2);
        end
      end
      if (wcnt2 == 0) begin mem_ready2 = 1'b1; mem_data2 = {7'b0, cur2}; end
      else wcnt2--;
    end else if (mem_read_req2) begin
      busy2 = 1; cur2 = mem_address2; wcnt2 = $urandom_range(0, 3);
      req_log2.push_back(mem_address2);
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (mem_read_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", mem_read_req); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", pix_valid); end
    checks++; if (pix_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", pix_data); end
    checks++; if (mem_address !== 25'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", mem_address); end
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL reset_underflow: got %0b want 0", underflow); end
    checks++; if (mem_address2 !== 25'h1FFFFFE) begin errors++; $display("FAIL reset_addr2: got %0h want 1fffffe", mem_address2); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (mem_read_req !== 1'b0) begin errors++; $display("FAIL idle_no_req: got %0b want 0", mem_read_req); end
  endtask

  task automatic test_underflow();
    pop = 1'b1;
    @(negedge clk) pop = 1'b0;
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set: got %0b want 1", underflow); end
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL underflow_valid: got %0b want 0", pix_valid); end
    repeat (5) @(negedge clk);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_sticky: got %0b want 1", underflow); end
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL underflow_clear: got %0b want 0", underflow); end
  endtask

  task automatic test_fill();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    req_log.delete();
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    repeat (150) @(negedge clk);
    checks++; if (req_log.size() != 15) begin errors++; $display("FAIL fill_reads: got %0d want 15", req_log.size()); end
    for (int k = 0; k < req_log.size() && k < 15; k++) begin
      checks++;
      if (req_log[k] !== 25'(k)) begin errors++; $display("FAIL fill_addr[%0d]: got %0h want %0h", k, req_log[k], k); end
    end
    checks++; if (mem_read_req !== 1'b0) begin errors++; $display("FAIL fill_stalled: req %0b want 0", mem_read_req); end
    checks++; if (pix_valid !== 1'b1 || pix_data !== 32'h0) begin
      errors++; $display("FAIL fill_head: valid %0b data %0h want 1/0", pix_valid, pix_data); end
  endtask

  task automatic test_drain();
    int got = 0;
    for (int c = 0; c < 2000 && got < 40; c++) begin
      @(negedge clk);
      pop = pix_valid && ($urandom_range(0, 3) != 0);
      if (pop) begin
        checks++;
        if (pix_data !== 32'(got)) begin errors++; $display("FAIL drain_data[%0d]: got %0h want %0h", got, pix_data, got); end
        got++;
      end
    end
    @(negedge clk) pop = 1'b0;
    checks++; if (got != 40) begin errors++; $display("FAIL drain_timeout: got %0d words want 40", got); end
    repeat (20) @(negedge clk);
    checks++; if (req_log.size() != 40) begin errors++; $display("FAIL drain_reads: got %0d want 40", req_log.size()); end
    for (int k = 0; k < req_log.size(); k++) begin
      checks++;
      if (req_log[k] !== 25'(k)) begin errors++; $display("FAIL drain_addr[%0d]: got %0h want %0h", k, req_log[k], k); end
    end
    checks++; if (mem_read_req !== 1'b0 || pix_valid !== 1'b0 || underflow !== 1'b0) begin
      errors++; $display("FAIL done_idle: req %0b valid %0b uf %0b want 0/0/0", mem_read_req, pix_valid, underflow); end
  endtask

  task automatic test_discard();
    bit found = 0;
    bit seen = 0;
    req_log.delete();
    frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    for (int c = 0; c < 200 && !found; c++) begin
      @(negedge clk);
      if (mem_read_req && mem_address == 25'h5) found = 1;
    end
    checks++; if (!found) begin errors++; $display("FAIL discard_req5: got none want request to 5"); end
    @(negedge clk) frame_start = 1'b1;
    @(negedge clk) frame_start = 1'b0;
    checks++; if (pix_valid !== 1'b0) begin errors++; $display("FAIL discard_flush: valid %0b want 0", pix_valid); end
    for (int c = 0; c < 50 && !seen; c++) begin
      @(negedge clk);
      if (pix_valid) seen = 1;
    end
    checks++; if (!seen || pix_data !== 32'h0) begin
      errors++; $display("FAIL discard_head: valid %0b data %0h want 1/0", seen, pix_data); end
    checks++; if (req_log.size() < 7 || req_log[5] !== 25'h5 || req_log[6] !== 25'h0) begin
      errors++; $display("FAIL discard_order: %0d reads, want 5 then 0 at entries 5/6", req_log.size()); end
    for (int k = 0; k < 4; k++) begin
      seen = 0;
      for (int c = 0; c < 50 && !seen; c++) begin
        if (pix_valid) seen = 1;
        else @(negedge clk);
      end
      checks++;
      if (pix_data !== 32'(k)) begin errors++; $display("FAIL discard_seq[%0d]: got %0h want %0h", k, pix_data, k); end
      pop = 1'b1;
      @(negedge clk) pop = 1'b0;
    end
  endtask

  task automatic test_reset_midwait();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (pix_valid !== 1'b0 || mem_read_req !== 1'b0 || pix_data !== 32'h0 || mem_address !== 25'h0) begin
      errors++; $display("FAIL midwait_reset: valid %0b req %0b data %0h addr %0h want 0/0/0/0",
                        pix_valid, mem_read_req, pix_data, mem_address); end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (mem_read_req !== 1'b0 || req_log.size() != 15) begin
      errors++; $display("FAIL midwait_idle: req %0b reads %0d want 0/15", mem_read_req, req_log.size()); end
  endtask

  task automatic test_wrap();
    int got = 0;
    logic [24:0] ea;
    req_log2.delete();
    frame_start2 = 1'b1;
    @(negedge clk) frame_start2 = 1'b0;
    for (int c = 0; c < 500 && got < 4; c++) begin
      @(negedge clk);
      pop2 = pix_valid2 && ($urandom_range(0, 1) == 1);
      if (pop2) begin
        ea = 25'h1FFFFFE + 25'(got);
        checks++;
        if (pix_data2 !== {7'b0, ea}) begin errors++; $display("FAIL wrap_data[%0d]: got %0h want %0h", got, pix_data2, ea); end
        got++;
      end
    end
    @(negedge clk) pop2 = 1'b0;
    checks++; if (got != 4) begin errors++; $display("FAIL wrap_timeout: got %0d words want 4", got); end
    repeat (20) @(negedge clk);
    checks++; if (req_log2.size() != 4) begin errors++; $display("FAIL wrap_reads: got %0d want 4", req_log2.size()); end
    for (int k = 0; k < req_log2.size(); k++) begin
      ea = 25'h1FFFFFE + 25'(k);
      checks++;
      if (req_log2[k] !== ea) begin errors++; $display("FAIL wrap_addr[%0d]: got %0h want %0h", k, req_log2[k], ea); end
    end
    checks++; if (mem_read_req2 !== 1'b0 || pix_valid2 !== 1'b0) begin
      errors++; $display("FAIL wrap_done: req %0b valid %0b want 0/0", mem_read_req2, pix_valid2); end
  endtask

  initial begin
    test_reset();
    test_underflow();
    test_fill();
    test_drain();
    test_discard();
    test_fill();
    test_reset_midwait();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
